fb_scanout: RTL and testbench

//   Read side of the 320x240 RGB444 frame buffer that the rasterizer writes.

---
 rtl/fb_scanout_if.sv | 24 ++
 rtl/fb_scanout.sv | 97 +++++++++
 tb/tb_fb_scanout.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/fb_scanout_if.sv
// Scan-out bundle: pixel enable, frame-buffer read port, bank-swap handshake and video pins.
interface fb_scanout_if;
  logic        i_pix_ce;
  logic [16:0] o_fb_addr;
  logic [11:0] i_fb_pixel;
  logic        o_front_sel;
  logic        i_swap_req;
  logic        o_swap_ack;
  logic        o_hsync;
  logic        o_vsync;
  logic        o_de;
  logic [11:0] o_rgb;
  logic        o_frame_start;

  modport master (
    input  i_pix_ce, i_fb_pixel, i_swap_req,
    output o_fb_addr, o_front_sel, o_swap_ack, o_hsync, o_vsync, o_de, o_rgb, o_frame_start
  );

  modport slave (
    output i_pix_ce, i_fb_pixel, i_swap_req,
    input  o_fb_addr, o_front_sel, o_swap_ack, o_hsync, o_vsync, o_de, o_rgb, o_frame_start
  );
endinterface

// File: rtl/fb_scanout.sv
// VGA scan-out of a pixel-doubled half-resolution frame buffer with tear-free bank swap.
// Latency counter->pins 2 pix_ce; no backpressure, everything advances only on i_pix_ce.
module fb_scanout #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int FB_W     = H_ACTIVE / 2
) (
  input  logic          i_clk,
  input  logic          i_rst,
  fb_scanout_if.master  bus
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  logic [9:0]  h_cnt;
  logic [9:0]  v_cnt;
  logic [16:0] row_base;
  logic        de1;
  logic        hs1;
  logic        vs1;
  logic        swap_pending;

  logic h_last;
  logic v_last;
  logic active0;
  logic hs0;
  logic vs0;
  logic swap_pt;

  assign h_last  = (h_cnt == 10'(H_TOTAL - 1));
  assign v_last  = (v_cnt == 10'(V_TOTAL - 1));
  assign active0 = (h_cnt < 10'(H_ACTIVE)) && (v_cnt < 10'(V_ACTIVE));
  assign hs0     = !((h_cnt >= 10'(H_ACTIVE + H_FP)) && (h_cnt < 10'(H_ACTIVE + H_FP + H_SYNC)));
  assign vs0     = !((v_cnt >= 10'(V_ACTIVE + V_FP)) && (v_cnt < 10'(V_ACTIVE + V_FP + V_SYNC)));
  // First blanking line: the displayed frame is finished, so the banks may swap.
  assign swap_pt = (h_cnt == 10'd0) && (v_cnt == 10'(V_ACTIVE));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      h_cnt             <= '0;
      v_cnt             <= '0;
      row_base          <= '0;
      de1               <= 1'b0;
      hs1               <= 1'b1;
      vs1               <= 1'b1;
      swap_pending      <= 1'b0;
      bus.o_fb_addr     <= '0;
      bus.o_front_sel   <= 1'b0;
      bus.o_swap_ack    <= 1'b0;
      bus.o_hsync       <= 1'b1;
      bus.o_vsync       <= 1'b1;
      bus.o_de          <= 1'b0;
      bus.o_rgb         <= '0;
      bus.o_frame_start <= 1'b0;
    end else begin
      bus.o_swap_ack    <= 1'b0;
      bus.o_frame_start <= 1'b0;
      if (bus.i_swap_req) swap_pending <= 1'b1;

      if (bus.i_pix_ce) begin
        h_cnt <= h_last ? 10'd0 : h_cnt + 10'd1;
        if (h_last) begin
          v_cnt <= v_last ? 10'd0 : v_cnt + 10'd1;
          // Each frame-buffer row is shown on two lines; advance after the odd one.
          if (v_last)        row_base <= '0;
          else if (v_cnt[0]) row_base <= row_base + 17'(FB_W);
        end

        if (active0) bus.o_fb_addr <= row_base + 17'(h_cnt[9:1]);
        de1 <= active0;
        hs1 <= hs0;
        vs1 <= vs0;

        bus.o_rgb   <= de1 ? bus.i_fb_pixel : 12'd0;
        bus.o_de    <= de1;
        bus.o_hsync <= hs1;
        bus.o_vsync <= vs1;

        if (h_cnt == 10'd0 && v_cnt == 10'd0) bus.o_frame_start <= 1'b1;

        if (swap_pt && (swap_pending || bus.i_swap_req)) begin
          bus.o_front_sel <= ~bus.o_front_sel;
          swap_pending    <= 1'b0;
          bus.o_swap_ack  <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_fb_scanout.sv
// Bench for fb_scanout on a scaled-down raster, against a position-based reference model.
module tb_fb_scanout;
  localparam int HA = 16, HFP = 2, HS = 4, HBP = 2;
  localparam int VA = 8,  VFP = 2, VS = 2, VBP = 2;
  localparam int HT = HA + HFP + HS + HBP;
  localparam int VT = VA + VFP + VS + VBP;
  localparam int FRAME = HT * VT;
  localparam int FBW = HA / 2;

  logic i_clk = 1'b0;
  logic i_rst;

  fb_scanout_if bus();

  fb_scanout #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP), .FB_W(FBW)
  ) dut (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .bus   (bus)
  );

  always #5 i_clk = ~i_clk;

  // Synchronous BRAM whose content at each address is the address itself.
  always @(posedge i_clk) bus.i_fb_pixel <= bus.o_fb_addr[11:0];

  int n;
  int errors;
  int checks;
  int acks, fss, de_cnt, hs_lo, vs_lo;
  bit m_sel, m_pend, m_ack, m_fs;
  bit rand_req;

  function automatic int hpos(int j); return j % HT; endfunction
  function automatic int vpos(int j); return (j / HT) % VT; endfunction
  function automatic int pix_addr(int h, int v); return (v / 2) * FBW + h / 2; endfunction

  // Address of the most recent visible position among the first cnt pixel enables.
  function automatic int exp_addr(int cnt);
    int h, v;
    if (cnt == 0) return 0;
    h = hpos(cnt - 1);
    v = vpos(cnt - 1);
    if (v >= VA) return pix_addr(HA - 1, VA - 1);
    if (h >= HA) return pix_addr(HA - 1, v);
    return pix_addr(h, v);
  endfunction

  function automatic int exp_de(int cnt);
    if (cnt < 2) return 0;
    return (hpos(cnt - 2) < HA && vpos(cnt - 2) < VA) ? 1 : 0;
  endfunction

  function automatic int exp_hs(int cnt);
    int h;
    if (cnt < 2) return 1;
    h = hpos(cnt - 2);
    return (h >= HA + HFP && h < HA + HFP + HS) ? 0 : 1;
  endfunction

  function automatic int exp_vs(int cnt);
    int v;
    if (cnt < 2) return 1;
    v = vpos(cnt - 2);
    return (v >= VA + VFP && v < VA + VFP + VS) ? 0 : 1;
  endfunction

  function automatic int exp_rgb(int cnt);
    if (exp_de(cnt) == 0) return 0;
    return pix_addr(hpos(cnt - 2), vpos(cnt - 2)) & 12'hFFF;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d (ce_count=%0d)", tag, obs, exp, n);
    end
  endtask

  // One clock: drive at negedge, advance the model, check every output after the edge.
  task automatic tick(input bit rst, input bit ce, input bit req);
    @(negedge i_clk);
    i_rst = rst;
    bus.i_pix_ce = ce;
    bus.i_swap_req = req;
    m_ack = 1'b0;
    m_fs = 1'b0;
    if (rst) begin
      n = 0;
      m_sel = 1'b0;
      m_pend = 1'b0;
    end else begin
      if (ce && hpos(n) == 0 && vpos(n) == VA && (m_pend || req)) begin
        m_sel = !m_sel;
        m_pend = 1'b0;
        m_ack = 1'b1;
      end else if (req) begin
        m_pend = 1'b1;
      end
      if (ce) begin
        m_fs = (n % FRAME == 0);
        n++;
      end
    end
    @(posedge i_clk);
    #1;
    chk("fb_addr", bus.o_fb_addr, exp_addr(n));
    chk("de", bus.o_de, exp_de(n));
    chk("hsync", bus.o_hsync, exp_hs(n));
    chk("vsync", bus.o_vsync, exp_vs(n));
    chk("rgb", bus.o_rgb, exp_rgb(n));
    chk("front_sel", bus.o_front_sel, m_sel);
    chk("swap_ack", bus.o_swap_ack, m_ack);
    chk("frame_start", bus.o_frame_start, m_fs);
    acks += int'(bus.o_swap_ack);
    fss  += int'(bus.o_frame_start);
    if (ce && !rst) begin
      de_cnt += int'(bus.o_de);
      hs_lo  += int'(!bus.o_hsync);
      vs_lo  += int'(!bus.o_vsync);
    end
  endtask

  task automatic ce_step(input bit req);
    int gap;
    gap = int'($urandom_range(1, 3));
    for (int i = 0; i < gap; i++) tick(1'b0, 1'b0, rand_req && ($urandom_range(0, 199) == 0));
    tick(1'b0, 1'b1, req);
  endtask

  // Step pixel enables until the next one lands on (h,v); that one carries req.
  task automatic run_until(input int h, input int v, input bit req);
    for (int k = 0; k < FRAME && !(hpos(n) == h && vpos(n) == v); k++) ce_step(1'b0);
    ce_step(req);
  endtask

  initial begin
    i_rst = 1'b1;
    bus.i_pix_ce = 1'b0;
    bus.i_swap_req = 1'b0;
    n = 0; errors = 0; checks = 0;
    acks = 0; fss = 0; de_cnt = 0; hs_lo = 0; vs_lo = 0;
    m_sel = 1'b0; m_pend = 1'b0; rand_req = 1'b0;

    // Reset, including a pixel enable and a swap request while held.
    tick(1'b1, 1'b0, 1'b0);
    tick(1'b1, 1'b1, 1'b1);
    tick(1'b1, 1'b0, 1'b0);

    // One full frame of timing.
    acks = 0; fss = 0; de_cnt = 0; hs_lo = 0; vs_lo = 0;
    for (int k = 0; k < FRAME; k++) ce_step(1'b0);
    chk("frame_de_count", de_cnt, HA * VA);
    chk("frame_hsync_low", hs_lo, HS * VT);
    chk("frame_vsync_low", vs_lo, VS * HT);
    chk("frame_start_count", fss, 1);
    chk("frame_no_ack", acks, 0);

    // Pixel doubling and addressing at fixed screen points.
    run_until(5, 3, 1'b0);
    ce_step(1'b0);
    chk("rgb_x5_y3", bus.o_rgb, 1 * FBW + 2);
    run_until(HA - 1, VA - 1, 1'b0);
    ce_step(1'b0);
    chk("rgb_last_pixel", bus.o_rgb, (VA / 2 - 1) * FBW + (HA / 2 - 1));

    // Single request during active video swaps only at the first blank line.
    acks = 0;
    run_until(7, 3, 1'b1);
    run_until(HA + HFP, VA - 1, 1'b0);
    chk("no_early_ack", acks, 0);
    chk("no_early_toggle", bus.o_front_sel, 0);
    run_until(0, VA, 1'b0);
    chk("swap_ack_at_point", bus.o_swap_ack, 1);
    chk("front_sel_toggled", bus.o_front_sel, 1);
    tick(1'b0, 1'b0, 1'b0);
    chk("swap_ack_one_clock", bus.o_swap_ack, 0);

    // Request on the exact swap clock, then one just after it plus two more.
    run_until(0, VA, 1'b1);
    chk("same_clock_ack", bus.o_swap_ack, 1);
    chk("same_clock_toggle", bus.o_front_sel, 0);
    acks = 0;
    ce_step(1'b1);
    run_until(3, 1, 1'b1);
    run_until(3, 5, 1'b1);
    chk("late_req_waits", acks, 0);
    run_until(0, VA, 1'b0);
    tick(1'b0, 1'b0, 1'b0);
    chk("absorbed_single_ack", acks, 1);
    chk("absorbed_single_toggle", bus.o_front_sel, 1);

    // Reset mid-frame with a swap pending.
    run_until(3, 2, 1'b1);
    run_until(9, 4, 1'b0);
    tick(1'b0, 1'b0, 1'b0);
    tick(1'b1, 1'b1, 1'b0);
    chk("rst_front_sel", bus.o_front_sel, 0);
    chk("rst_de", bus.o_de, 0);
    chk("rst_addr", bus.o_fb_addr, 0);
    acks = 0; fss = 0;
    tick(1'b0, 1'b0, 1'b0);
    ce_step(1'b0);
    chk("restart_frame_start", fss, 1);

    // Long pixel-enable stall mid-line.
    run_until(5, 2, 1'b0);
    for (int k = 0; k < 50; k++) tick(1'b0, 1'b0, 1'b0);
    run_until(0, VA, 1'b0);
    tick(1'b0, 1'b0, 1'b0);
    chk("pending_lost_no_ack", acks, 0);
    chk("pending_lost_front_sel", bus.o_front_sel, 0);

    // Random requests on any clock over two frames.
    rand_req = 1'b1;
    for (int k = 0; k < 2 * FRAME; k++) ce_step($urandom_range(0, 59) == 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
